// File: rtl/accu_rr_sched.sv
// Round-robin front end for a shared GROUP-beat accumulator: grants one channel per burst,
// forwards its beats, captures the channel-tagged sum and holds it until the consumer takes it.
module accu_rr_sched #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int GROUP  = 4,
  parameter int OW     = 10,
  parameter int CHW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*DW-1:0] req_data,
  output logic [NUM_CH-1:0]    req_ready,
  output logic                 acc_valid_in,
  output logic [DW-1:0]        acc_data_in,
  input  logic                 acc_valid_out,
  input  logic [OW-1:0]        acc_data_out,
  output logic                 res_valid,
  output logic [OW-1:0]        res_data,
  output logic [CHW-1:0]       res_ch,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 err_spur
);

  localparam int CNTW = $clog2(GROUP + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, HOLD} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CHW-1:0]  rr;
  logic [CHW-1:0]  gch;
  logic [CHW-1:0]  pick_ch;
  logic [CHW-1:0]  rr_nx;
  logic [CNTW-1:0] cnt;
  logic [DW-1:0]   sel_data;
  logic            sel_valid;
  logic            beat;
  logic            last_beat;
  logic            accept;

  // First requester at or after the pointer, wrapping modulo NUM_CH (NUM_CH need not be a power of 2).
  function automatic logic [CHW-1:0] rr_pick(input logic [NUM_CH-1:0] v, input logic [CHW-1:0] p);
    logic [CHW-1:0] r;
    logic [CHW:0]   s;
    logic           found;
    r     = p;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      s = {1'b0, p} + (CHW+1)'(i);
      if (s >= (CHW+1)'(NUM_CH)) s = s - (CHW+1)'(NUM_CH);
      if (!found && v[s[CHW-1:0]]) begin
        r     = s[CHW-1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign pick_ch = rr_pick(req_valid, rr);
  assign rr_nx   = (gch == CHW'(NUM_CH - 1)) ? '0 : gch + CHW'(1);

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gch == CHW'(i)) begin
        sel_data  = req_data[i*DW +: DW];
        sel_valid = req_valid[i];
      end
    end
  end

  assign beat      = (state == GRANT) && sel_valid;
  assign last_beat = beat && (cnt == CNTW'(GROUP - 1));
  assign accept    = (state == HOLD) && res_valid && res_ready;
  assign busy      = (state != IDLE);

  // Beats pass straight through to the accumulator while the grant is held.
  always_comb begin
    req_ready    = '0;
    acc_valid_in = 1'b0;
    acc_data_in  = '0;
    if (state == GRANT) begin
      for (int i = 0; i < NUM_CH; i++) req_ready[i] = (gch == CHW'(i));
      acc_valid_in = beat;
      acc_data_in  = sel_data;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid)    state_nx = GRANT;
      GRANT:   if (last_beat)     state_nx = WAIT;
      WAIT:    if (acc_valid_out) state_nx = HOLD;
      HOLD:    if (accept)        state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      gch       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
      err_spur  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req_valid) gch <= pick_ch;
      if (beat) cnt <= last_beat ? '0 : cnt + CNTW'(1);
      if (state == WAIT && acc_valid_out) begin
        res_valid <= 1'b1;
        res_data  <= acc_data_out;
        res_ch    <= gch;
      end
      // Pointer moves only once the result has left, so a slow consumer cannot skip a channel.
      if (accept) begin
        res_valid <= 1'b0;
        rr        <= rr_nx;
      end
      if (acc_valid_out && state != WAIT) err_spur <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accu_rr_sched.sv
// Bench for accu_rr_sched with a behavioural 4-beat accumulator and beat/result scoreboards.
module tb_accu_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        acc_valid_in;
  logic [7:0]  acc_data_in;
  logic        acc_valid_out;
  logic [9:0]  acc_data_out;
  logic        res_valid;
  logic [9:0]  res_data;
  logic [1:0]  res_ch;
  logic        res_ready;
  logic        busy;
  logic        err_spur;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] d;
  } item_t;

  item_t beat_q[$];
  item_t res_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  int    rise_t[$];
  logic  prev_rv = 1'b0;

  logic       inj;
  logic       avo;
  logic [9:0] asum;
  logic [2:0] acnt;

  accu_rr_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .acc_valid_in(acc_valid_in), .acc_data_in(acc_data_in), .acc_valid_out(acc_valid_out),
    .acc_data_out(acc_data_out), .res_valid(res_valid), .res_data(res_data), .res_ch(res_ch),
    .res_ready(res_ready), .busy(busy), .err_spur(err_spur)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared accumulator: sum valid one cycle after the 4th beat.
  always @(posedge clk) begin
    if (rst) begin
      avo <= 1'b0; asum <= '0; acnt <= '0; acc_data_out <= '0;
    end else begin
      avo <= 1'b0;
      if (acc_valid_in) begin
        if (acnt == 3'd3) begin
          avo <= 1'b1; acc_data_out <= asum + 10'(acc_data_in); asum <= '0; acnt <= '0;
        end else begin
          asum <= asum + 10'(acc_data_in); acnt <= acnt + 3'd1;
        end
      end
    end
  end
  assign acc_valid_out = avo | inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected beats and results whenever the DUT presents them.
  always @(negedge clk) begin
    item_t e;
    if (!rst) begin
      if (acc_valid_in) begin
        beat_cnt++;
        if (beat_q.size() == 0) chk("beat_unexpected", {24'd0, acc_data_in}, 32'hFFFF_FFFF);
        else begin
          e = beat_q.pop_front();
          chk("beat_data", {24'd0, acc_data_in}, {22'd0, e.d});
          chk("beat_ready", {28'd0, req_ready}, 32'(4'd1 << e.ch));
        end
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) chk("res_unexpected", {22'd0, res_data}, 32'hFFFF_FFFF);
        else begin
          e = res_q.pop_front();
          chk("res_data", {22'd0, res_data}, {22'd0, e.d});
          chk("res_ch", {30'd0, res_ch}, {30'd0, e.ch});
        end
      end
      if (res_valid && !prev_rv) rise_t.push_back(cyc);
    end
    prev_rv = res_valid;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; inj = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_beat(input int ch, input logic [7:0] d);
    int n;
    req_valid[ch] = 1'b1;
    req_data[ch*8 +: 8] = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[ch] && n < 50);
    if (!req_ready[ch]) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_burst(input int ch, input logic [7:0] d0, d1, d2, d3, input logic [9:0] sum);
    beat_q.push_back('{2'(ch), 10'(d0)});
    beat_q.push_back('{2'(ch), 10'(d1)});
    beat_q.push_back('{2'(ch), 10'(d2)});
    beat_q.push_back('{2'(ch), 10'(d3)});
    res_q.push_back('{2'(ch), sum});
  endtask

  task automatic drain();
    int n = 0;
    while ((res_q.size() != 0 || beat_q.size() != 0) && n < 300) begin @(negedge clk); n++; end
    chk("drain_res_q", res_q.size(), 0);
    chk("drain_beat_q", beat_q.size(), 0);
  endtask

  task automatic wait_res_valid();
    int n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 50);
    chk("res_valid_timeout", {31'd0, res_valid}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0; inj = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_data", {22'd0, res_data}, 0);
    chk("rst_res_ch", {30'd0, res_ch}, 0);
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_acc_valid_in", {31'd0, acc_valid_in}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err_spur", {31'd0, err_spur}, 0);

    // 1: single burst on ch0, latency of the result
    expect_burst(0, 1, 2, 3, 4, 10'd10);
    do_beat(0, 1); do_beat(0, 2); do_beat(0, 3); do_beat(0, 4);
    req_valid = '0;
    @(negedge clk);
    chk("t1_res_valid_wait", {31'd0, res_valid}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    @(negedge clk);
    chk("t1_res_valid_2cyc", {31'd0, res_valid}, 1);
    chk("t1_res_data", {22'd0, res_data}, 10);
    @(posedge clk); #1 res_ready = 1'b1;
    drain();

    // 2: all channels requesting, round-robin order and 7-cycle cadence
    do_reset();
    res_ready = 1'b1;
    rise_t.delete();
    for (int b = 0; b < 5; b++)
      expect_burst(b % 4, 8'(b % 4 + 1), 8'(b % 4 + 1), 8'(b % 4 + 1), 8'(b % 4 + 1),
                   10'(4 * (b % 4 + 1)));
    req_data = {8'd4, 8'd3, 8'd2, 8'd1};
    beat_cnt = 0;
    req_valid = 4'hF;
    for (int n = 0; n < 200 && beat_cnt < 20; n++) @(posedge clk);
    #1 req_valid = '0;
    drain();
    chk("t2_num_results", rise_t.size(), 5);
    for (int k = 1; k < 5 && k < rise_t.size(); k++)
      chk("t2_spacing", rise_t[k] - rise_t[k-1], 7);

    // 3: stalled consumer, max-value sum held, no further grant
    do_reset();
    res_ready = 1'b0;
    expect_burst(2, 255, 255, 255, 255, 10'd1020);
    do_beat(2, 255); do_beat(2, 255); do_beat(2, 255); do_beat(2, 255);
    req_valid[2] = 1'b0;
    req_valid[0] = 1'b1; req_data[7:0] = 8'd9;
    wait_res_valid();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, res_valid}, 1);
      chk("t3_hold_data", {22'd0, res_data}, 1020);
      chk("t3_hold_ch", {30'd0, res_ch}, 2);
      chk("t3_no_ready", {28'd0, req_ready}, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1; req_valid[0] = 1'b0;
    drain();

    // 4: gaps on the granted channel while another channel requests
    do_reset();
    res_ready = 1'b1;
    expect_burst(1, 1, 2, 3, 4, 10'd10);
    do_beat(1, 1); do_beat(1, 2);
    req_valid[1] = 1'b0; req_valid[3] = 1'b1; req_data[31:24] = 8'd77;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t4_grant_locked", {28'd0, req_ready}, 32'b0010);
      chk("t4_no_beat", {31'd0, acc_valid_in}, 0);
    end
    @(posedge clk); #1;
    do_beat(1, 3); do_beat(1, 4);
    req_valid = '0;
    drain();

    // 5: reset mid-burst discards the partial sum
    do_reset();
    res_ready = 1'b1;
    beat_q.push_back('{2'd0, 10'd1});
    beat_q.push_back('{2'd0, 10'd2});
    do_beat(0, 1); do_beat(0, 2);
    req_valid = '0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("t5_no_res", {31'd0, res_valid}, 0);
      chk("t5_idle", {31'd0, busy}, 0);
    end
    expect_burst(0, 5, 5, 5, 5, 10'd20);
    @(posedge clk); #1;
    do_beat(0, 5); do_beat(0, 5); do_beat(0, 5); do_beat(0, 5);
    req_valid = '0;
    drain();

    // 6: spurious accumulator valid in IDLE
    do_reset();
    res_ready = 1'b1;
    inj = 1'b1;
    @(posedge clk); #1 inj = 1'b0;
    @(negedge clk);
    chk("t6_err_set", {31'd0, err_spur}, 1);
    chk("t6_no_res", {31'd0, res_valid}, 0);
    chk("t6_idle", {31'd0, busy}, 0);
    expect_burst(0, 7, 8, 9, 10, 10'd34);
    @(posedge clk); #1;
    do_beat(0, 7); do_beat(0, 8); do_beat(0, 9); do_beat(0, 10);
    req_valid = '0;
    drain();
    chk("t6_err_sticky", {31'd0, err_spur}, 1);
    do_reset();
    @(negedge clk);
    chk("t6_err_cleared", {31'd0, err_spur}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
